// File: rtl/fp32_adder.sv
// IEEE-754 binary32 adder with round-to-nearest-even and one output register.
// Subnormals are handled on both input and output. NaN results are canonical.
module fp32_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] sum
);

    logic        w_sa, w_sb;
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_fa, w_fb;
    logic [7:0]  w_xea, w_xeb;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [31:0] w_ka, w_kb;
    logic        w_swap;
    logic [7:0]  w_eh, w_el, w_d;
    logic [23:0] w_mh, w_ml;
    logic        w_sgn, w_sub;
    logic [4:0]  w_dc;
    logic [49:0] w_ext;
    logic [26:0] w_al, w_bg;
    logic [27:0] w_s;

    assign w_sa = a[31];
    assign w_sb = b[31];
    assign w_ea = a[30:23];
    assign w_eb = b[30:23];
    assign w_fa = a[22:0];
    assign w_fb = b[22:0];

    assign w_xea = (w_ea == 8'd0) ? 8'd1 : w_ea;
    assign w_xeb = (w_eb == 8'd0) ? 8'd1 : w_eb;

    assign w_a_nan = (&w_ea) & (|w_fa);
    assign w_b_nan = (&w_eb) & (|w_fb);
    assign w_a_inf = (&w_ea) & ~(|w_fa);
    assign w_b_inf = (&w_eb) & ~(|w_fb);

    // Magnitude keys: effective exponent, hidden bit, fraction.
    assign w_ka = {w_xea, w_ea != 8'd0, w_fa};
    assign w_kb = {w_xeb, w_eb != 8'd0, w_fb};
    assign w_swap = w_kb > w_ka;

    assign w_eh  = w_swap ? w_xeb : w_xea;
    assign w_el  = w_swap ? w_xea : w_xeb;
    assign w_mh  = w_swap ? w_kb[23:0] : w_ka[23:0];
    assign w_ml  = w_swap ? w_ka[23:0] : w_kb[23:0];
    assign w_sgn = w_swap ? w_sb : w_sa;
    assign w_sub = w_sa ^ w_sb;

    assign w_d  = w_eh - w_el;
    assign w_dc = (w_d > 8'd26) ? 5'd26 : w_d[4:0];

    // Mantissa, guard and round on top; everything below folds into sticky.
    assign w_ext = {w_ml, 26'd0} >> w_dc;
    assign w_al  = {w_ext[49:24], |w_ext[23:0]};
    assign w_bg  = {w_mh, 3'b000};

    assign w_s = w_sub ? ({1'b0, w_bg} - {1'b0, w_al})
                       : ({1'b0, w_bg} + {1'b0, w_al});

    logic [4:0]  w_lz, w_sh;
    logic [7:0]  w_lim;
    logic [26:0] w_m;
    logic [9:0]  w_e, w_ef;
    logic        w_up;
    logic [24:0] w_mr;
    logic [22:0] w_frac;
    logic [31:0] w_res;

    always_comb begin
        w_lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (w_s[i]) w_lz = 5'(26 - i);
        end
        // Left shift stops at exponent 1, leaving a subnormal.
        w_lim = w_eh - 8'd1;
        if ({3'b000, w_lz} < w_lim) w_sh = w_lz;
        else w_sh = w_lim[4:0];

        if (w_s[27]) begin
            w_m = {w_s[27:2], w_s[1] | w_s[0]};
            w_e = {2'b00, w_eh} + 10'd1;
        end else begin
            w_m = w_s[26:0] << w_sh;
            w_e = {2'b00, w_eh} - {5'd0, w_sh};
        end

        w_up = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
        w_mr = {1'b0, w_m[26:3]} + {24'd0, w_up};

        if (w_mr[24]) begin
            w_frac = w_mr[23:1];
            w_ef   = w_e + 10'd1;
        end else begin
            w_frac = w_mr[22:0];
            w_ef   = w_mr[23] ? w_e : 10'd0;
        end

        w_res = {w_sgn, w_ef[7:0], w_frac};
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & w_sub))
            w_res = 32'h7FC0_0000;
        else if (w_a_inf)
            w_res = a;
        else if (w_b_inf)
            w_res = b;
        else if (w_s == 28'd0)
            w_res = {~w_sub & w_sgn, 31'd0};
        else if (w_ef >= 10'd255)
            w_res = {w_sgn, 8'hFF, 23'd0};
    end

    logic        r_valid;
    logic [31:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= 32'd0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) r_sum <= w_res;
        end
    end

    assign out_valid = r_valid;
    assign sum       = r_sum;

endmodule

// File: tb/tb_fp32_adder.sv
// Directed and random checks of fp32_adder against a real-arithmetic model.
module tb_fp32_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic [31:0] sum;

    int checks = 0;
    int failures = 0;
    logic [31:0] last;

    always #5 clk = ~clk;

    fp32_adder dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .sum(sum)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp,
                        input string tag);
        in_valid = v;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, "_sum"}, sum, exp);
    endtask

    function automatic real f2r(input logic [31:0] x);
        int e = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        int mant = (x[30:23] == 8'd0) ? int'(x[22:0]) : int'({1'b1, x[22:0]});
        logic [63:0] sc = {1'b0, 11'(1023 + e - 150), 52'd0};
        real v = $itor(mant) * $bitstoreal(sc);
        return x[31] ? -v : v;
    endfunction

    // Exact double -> binary32 with ties-to-even, subnormals and overflow.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d = $realtobits(r);
        int ef = int'(d[62:52]) - 896;
        int eff = (ef < 1) ? 1 : ef;
        int sh = 29 + eff - ef;
        longint unsigned sig = {11'd0, 1'b1, d[51:0]};
        longint unsigned q, rem, half, field;
        if (sh > 60) return {d[63], 31'd0};
        q = sig >> sh;
        rem = sig - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        field = (64'(eff - 1) << 23) + q;
        if (field >= 64'h7F80_0000) return {d[63], 8'hFF, 23'd0};
        return {d[63], field[30:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] x,
                                            input logic [31:0] y);
        logic xn = (&x[30:23]) && (|x[22:0]);
        logic yn = (&y[30:23]) && (|y[22:0]);
        logic xi = (&x[30:23]) && !(|x[22:0]);
        logic yi = (&y[30:23]) && !(|y[22:0]);
        real s;
        if (xn || yn) return 32'h7FC0_0000;
        if (xi && yi) return (x[31] == y[31]) ? x : 32'h7FC0_0000;
        if (xi) return x;
        if (yi) return y;
        if (x[30:0] == 31'd0 && y[30:0] == 31'd0)
            return {x[31] & y[31], 31'd0};
        s = f2r(x) + f2r(y);
        if (s == 0.0) return 32'd0;
        return r2f(s);
    endfunction

    function automatic logic [31:0] rnd_op(input logic [31:0] other);
        logic [31:0] u = $urandom;
        int sel = $urandom_range(0, 5);
        int k = $urandom_range(0, 7);
        logic [31:0] sp[8] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                               32'h7F80_0001, 32'h0000_0000, 32'h8000_0000,
                               32'h7F7F_FFFF, 32'h0000_0001};
        logic [7:0] e;
        case (sel)
            0: return u;
            1: begin
                e = other[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
                return {u[31], e, u[22:0]};
            end
            2: return {u[31], 8'($urandom_range(0, 1)), u[22:0]};
            3: return {~other[31], other[30:1], u[0]};
            4: return sp[k];
            default: return {u[31], 8'($urandom_range(250, 254)), u[22:0]};
        endcase
    endfunction

    initial begin
        logic [31:0] x, y, e;

        in_valid = 1'b1;
        a = 32'h3F80_0000;
        b = 32'h3F80_0000;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_sum", sum, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_sum", sum, 32'h4000_0000);
        chk("first_valid", {31'd0, out_valid}, 32'd1);

        step(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, "add");
        step(1'b1, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, "cancel");
        step(1'b1, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, "sub");
        step(1'b1, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "tie_even");
        step(1'b1, 32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, "above_half");
        step(1'b1, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, "tie_up");
        step(1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow");
        step(1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, "sub_add");
        step(1'b1, 32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF, "to_sub");
        step(1'b1, 32'h007F_FFFF, 32'h0000_0001, 32'h0080_0000, "to_norm");
        step(1'b1, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf_minf");
        step(1'b1, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
        step(1'b1, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, "minf_fin");
        step(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "mz_mz");
        step(1'b1, 32'h0001_2345, 32'h8000_0000, 32'h0001_2345, "sub_pz");
        step(1'b1, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, "mz_pz");
        last = 32'h0000_0000;

        for (int i = 0; i < 3; i++) begin
            step(1'b0, $urandom, $urandom, last, "hold");
        end

        for (int i = 0; i < 1000; i++) begin
            x = rnd_op($urandom);
            y = rnd_op(x);
            if ($urandom_range(0, 1) == 1) begin
                e = x;
                x = y;
                y = e;
            end
            e = ref_add(x, y);
            step(1'b1, x, y, e, $sformatf("rnd%0d_%h_%h", i, x, y));
        end

        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sum", sum, 32'd0);
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        #1 rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp32_adder.md
Name: fp32_adder

Overview:
IEEE-754 binary32 adder: sum = a + b, computed combinationally and captured in one output register stage. Used as the floating-point add unit of the ALU. It accepts one operand pair per cycle, with a simple valid flag travelling alongside the data. There are no exception flag outputs.

Parameters:
None.

Ports:
clk        input   1   clock; all state updates on the rising edge
rst_n      input   1   asynchronous, active-low reset
in_valid   input   1   a and b hold an operand pair this cycle
a          input   32  operand A, binary32 bit pattern
b          input   32  operand B, binary32 bit pattern
out_valid  output  1   sum holds a new result
sum        output  32  registered binary32 result of a + b

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n = 0, sum = 0x00000000 and out_valid = 0, immediately, independent of clk.
  - The first capture happens on the first rising clk edge after rst_n deasserts.
- Latency and throughput:
  - Latency is 1 cycle. At each rising edge with rst_n = 1: out_valid <= in_valid.
  - If in_valid = 1, sum <= round(a + b). If in_valid = 0, sum holds its previous value.
  - Full throughput: a new pair can be accepted every cycle. There is no backpressure and no stall input.
- Arithmetic datapath:
  - Unpack both operands. Subnormals are fully supported on input and output: hidden bit 0 and effective exponent 1 when the exponent field is 0.
  - Order the operands by magnitude (exponent, then mantissa). The larger operand sets the result sign when the effective signs differ.
  - Align the smaller operand by shifting right by the exponent difference, keeping guard, round and sticky bits. If the shift is 26 or more, the whole smaller mantissa collapses into sticky.
  - Effective add when the signs are equal, effective subtract otherwise.
  - Normalise:
    - Carry-out shifts right by 1 (folding the lost bit into sticky) and increments the exponent.
    - After a subtract, a leading-zero count shifts left, limited so the exponent does not go below 1. Hitting that limit produces a subnormal.
  - Rounding is round-to-nearest, ties-to-even. A mantissa overflow after rounding renormalises and increments the exponent.
  - An exponent of 255 or more after rounding produces a correctly signed infinity: 0x7F800000 or 0xFF800000.
- Special cases, highest priority first:
  - Either input is NaN: result is the canonical quiet NaN 0x7FC00000.
  - +Inf + -Inf: 0x7FC00000.
  - Inf + any finite value: that infinity.
  - Inf + the same-signed Inf: that infinity.
- Zero results:
  - An exact zero from x + (-x) is +0.
  - -0 + -0 = -0 (0x80000000).
  - +0 + -0 = +0.
  - x + ±0 = x exactly, including subnormal x.
- Inputs are sampled only at the clock edge. Changes to a/b between edges have no effect on sum.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1, a = 0x3F800000 → sum = 0x00000000 and out_valid = 0 with no clock edge. Release rst_n, then one edge → sum = 0x40000000 when b = 0x3F800000.
- Normal add/sub, one result per cycle, each appearing 1 cycle later:
  - 0x3F800000 + 0x40000000 → 0x40400000.
  - 0x3F800000 + 0xBF800000 → 0x00000000.
  - 0x40400000 + 0xBF800000 → 0x40000000.
- Rounding:
  - 0x3F800000 + 0x33800000 → 0x3F800000 (tie to even).
  - 0x3F800000 + 0x33800001 → 0x3F800001.
  - 0x3F800001 + 0x33800000 → 0x3F800002 (tie rounds up to even).
- Range edges:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x00000001 + 0x00000001 → 0x00000002.
  - 0x00800000 + 0x80000001 → 0x007FFFFF (normal to subnormal).
  - 0x007FFFFF + 0x00000001 → 0x00800000 (subnormal to normal).
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0x7FC00001 + 0x3F800000 → 0x7FC00000.
  - 0xFF800000 + 0x3F800000 → 0xFF800000.
  - 0x80000000 + 0x80000000 → 0x80000000.
  - 0x80000000 + 0x00000000 → 0x00000000.
- Hold/valid: in_valid = 0 for 3 cycles with changing a/b → sum unchanged and out_valid = 0. Then a 1000-pair random regression checked against a reference binary32 model, bit-exact except that all NaN results must equal 0x7FC00000.
